// File: rtl/div_op_sequencer.sv
// ---------------------------------------------------------------------------
// div_op_sequencer
//
// Sequential wrapper around a purely combinational divider. A request
// (dividend/divisor) is accepted over a valid/ready handshake and driven,
// held stable, into the divider's OperA/OperD. After a fixed settle time the
// divider Quotient is captured, the remainder is derived from it, and the
// result is offered over a second valid/ready handshake. A zero divisor
// bypasses the divider and returns an all-ones quotient with a flag.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready   request handshake
//   in_dividend         dividend, DEVIDENT_LENGTH bits
//   in_divisor          divisor, DIVISOR_LENGTH bits
//   div_OperA/OperD     registered operands to the divider
//   div_Quotient        quotient from the divider
//   out_valid/out_ready result handshake
//   out_quotient        registered quotient
//   out_remainder       registered remainder
//   out_div_by_zero     result came from a zero divisor
// ---------------------------------------------------------------------------
module div_op_sequencer #(
    parameter int DEVIDENT_LENGTH = 10,
    parameter int DIVISOR_LENGTH  = 5,
    parameter int SETTLE_CYCLES   = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DEVIDENT_LENGTH-1:0] in_dividend,
    input  logic [DIVISOR_LENGTH-1:0]  in_divisor,
    output logic [DEVIDENT_LENGTH-1:0] div_OperA,
    output logic [DIVISOR_LENGTH-1:0]  div_OperD,
    input  logic [DEVIDENT_LENGTH-1:0] div_Quotient,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DEVIDENT_LENGTH-1:0] out_quotient,
    output logic [DIVISOR_LENGTH-1:0]  out_remainder,
    output logic                       out_div_by_zero
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [DEVIDENT_LENGTH-1:0] opa_q, opa_d;
    logic [DIVISOR_LENGTH-1:0]  opd_q, opd_d;
    logic                       valid_q, valid_d;
    logic [DEVIDENT_LENGTH-1:0] quot_q, quot_d;
    logic [DIVISOR_LENGTH-1:0]  rem_q, rem_d;
    logic                       dz_q, dz_d;

    // Remainder = OperA - Quotient*OperD. Only the low DEVIDENT_LENGTH bits
    // of the full-width product reach the difference, and those low bits are
    // identical to a DEVIDENT_LENGTH-wide product, so the multiply is kept
    // at that width.
    logic [DEVIDENT_LENGTH-1:0] opd_ext;
    logic [DEVIDENT_LENGTH-1:0] prod_lo;
    logic [DIVISOR_LENGTH-1:0]  rem_calc;

    assign opd_ext  = {{(DEVIDENT_LENGTH-DIVISOR_LENGTH){1'b0}}, opd_q};
    assign prod_lo  = div_Quotient * opd_ext;
    assign rem_calc = DIVISOR_LENGTH'(opa_q - prod_lo);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        opa_d   = opa_q;
        opd_d   = opd_q;
        valid_d = valid_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dz_d    = dz_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    opa_d = in_dividend;
                    opd_d = in_divisor;
                    if (in_divisor == '0) begin
                        // Zero divisor: answer immediately, divider unused.
                        quot_d  = '1;
                        rem_d   = '0;
                        dz_d    = 1'b1;
                        valid_d = 1'b1;
                        state_d = DONE;
                    end else begin
                        cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    quot_d  = div_Quotient;
                    rem_d   = rem_calc;
                    dz_d    = 1'b0;
                    valid_d = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            opa_q   <= '0;
            opd_q   <= '0;
            valid_q <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            opa_q   <= opa_d;
            opd_q   <= opd_d;
            valid_q <= valid_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
        end
    end

    // Gated with rst so no request is taken while reset is applied.
    assign in_ready        = (state_q == IDLE) && !rst;
    assign div_OperA       = opa_q;
    assign div_OperD       = opd_q;
    assign out_valid       = valid_q;
    assign out_quotient    = quot_q;
    assign out_remainder   = rem_q;
    assign out_div_by_zero = dz_q;

endmodule

// File: tb/tb_div_op_sequencer.sv
module tb_div_op_sequencer;

    logic       clk = 1'b0;
    logic       rst;

    // DUT with SETTLE_CYCLES = 2
    logic       in_valid, in_ready, out_valid, out_ready, out_dz;
    logic [9:0] in_dividend, opa, quot_in, out_q;
    logic [4:0] in_divisor, opd, out_r;

    // DUT with SETTLE_CYCLES = 1
    logic       in_valid1, in_ready1, out_valid1, out_ready1, out_dz1;
    logic [9:0] in_dividend1, opa1, quot_in1, out_q1;
    logic [4:0] in_divisor1, opd1, out_r1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Behavioural combinational divider feeding each DUT.
    assign quot_in  = (opd  != 5'd0) ? opa  / {5'd0, opd}  : 10'h3ff;
    assign quot_in1 = (opd1 != 5'd0) ? opa1 / {5'd0, opd1} : 10'h3ff;

    div_op_sequencer #(.DEVIDENT_LENGTH(10), .DIVISOR_LENGTH(5), .SETTLE_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_dividend(in_dividend), .in_divisor(in_divisor),
        .div_OperA(opa), .div_OperD(opd), .div_Quotient(quot_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_quotient(out_q), .out_remainder(out_r), .out_div_by_zero(out_dz)
    );

    div_op_sequencer #(.DEVIDENT_LENGTH(10), .DIVISOR_LENGTH(5), .SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid1), .in_ready(in_ready1),
        .in_dividend(in_dividend1), .in_divisor(in_divisor1),
        .div_OperA(opa1), .div_OperD(opd1), .div_Quotient(quot_in1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .out_quotient(out_q1), .out_remainder(out_r1), .out_div_by_zero(out_dz1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Issue one request on the SETTLE_CYCLES=2 DUT with out_ready=1 and check
    // operands, latency, result and the return of in_ready.
    task automatic run(input logic [9:0] a, input logic [4:0] d,
                       input logic [9:0] eq, input logic [4:0] er,
                       input logic edz, input int elat);
        int lat;
        chk("ready_before", in_ready, 1);
        in_valid    = 1'b1;
        in_dividend = a;
        in_divisor  = d;
        @(negedge clk);
        in_valid = 1'b0;
        chk("opa_latch", opa, a);
        chk("opd_latch", opd, d);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
            chk("opa_stable", opa, a);
        end
        chk("latency", lat, elat);
        chk("quotient", out_q, eq);
        chk("remainder", out_r, er);
        chk("div_by_zero", out_dz, edz);
        chk("ready_busy", in_ready, 0);
        @(negedge clk);
        chk("valid_cleared", out_valid, 0);
        chk("ready_back", in_ready, 1);
    endtask

    initial begin
        rst          = 1'b1;
        in_valid     = 1'b0;
        in_dividend  = '0;
        in_divisor   = '0;
        out_ready    = 1'b1;
        in_valid1    = 1'b0;
        in_dividend1 = '0;
        in_divisor1  = '0;
        out_ready1   = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_opa", opa, 0);
        chk("rst_opd", opd, 0);
        chk("rst_quot", out_q, 0);
        chk("rst_rem", out_r, 0);
        chk("rst_dz", out_dz, 0);
        rst = 1'b0;
        @(negedge clk);

        // Normal divisions
        run(10'd21,   5'd7,  10'd3,    5'd0, 1'b0, 2);
        run(10'd100,  5'd7,  10'd14,   5'd2, 1'b0, 2);
        run(10'd1023, 5'd31, 10'd33,   5'd0, 1'b0, 2);

        // Divide by zero, then flag cleared by the next normal request
        run(10'd5,    5'd0,  10'd1023, 5'd0, 1'b1, 0);
        run(10'd28,   5'd7,  10'd4,    5'd0, 1'b0, 2);

        // Backpressure: result held, new requests ignored
        out_ready   = 1'b0;
        in_valid    = 1'b1;
        in_dividend = 10'd14;
        in_divisor  = 5'd2;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("bp_valid_up", out_valid, 1);
        in_valid    = 1'b1;
        in_dividend = 10'd3;
        in_divisor  = 5'd1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", out_valid, 1);
            chk("bp_quot", out_q, 7);
            chk("bp_rem", out_r, 0);
            chk("bp_ready", in_ready, 0);
            chk("bp_opa_kept", opa, 14);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_done_valid", out_valid, 0);
        chk("bp_done_ready", in_ready, 1);
        chk("bp_opa_final", opa, 14);

        // Reset in the middle of WAIT
        in_valid    = 1'b1;
        in_dividend = 10'd12;
        in_divisor  = 5'd3;
        @(negedge clk);
        in_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("mrst_opa", opa, 0);
        chk("mrst_opd", opd, 0);
        chk("mrst_ready", in_ready, 0);
        chk("mrst_valid", out_valid, 0);
        chk("mrst_quot", out_q, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("mrst_no_valid", out_valid, 0);
        end
        run(10'd12, 5'd3, 10'd4, 5'd0, 1'b0, 2);

        // SETTLE_CYCLES = 1 instance
        chk("s1_ready", in_ready1, 1);
        in_valid1    = 1'b1;
        in_dividend1 = 10'd1;
        in_divisor1  = 5'd1;
        @(negedge clk);
        in_valid1 = 1'b0;
        chk("s1_valid_early", out_valid1, 0);
        @(negedge clk);
        chk("s1_valid", out_valid1, 1);
        chk("s1_quot", out_q1, 1);
        chk("s1_rem", out_r1, 0);
        chk("s1_dz", out_dz1, 0);
        @(negedge clk);
        chk("s1_cleared", out_valid1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
